mem_bus_arbiter: RTL and testbench



---
 rtl/mem_bus_arbiter_if.sv | 49 ++++
 rtl/mem_bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the icache/dcache requesters, the arbiter and memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
`ifndef XLEN
`define XLEN 64
`endif

interface mem_bus_arbiter_if #(
    parameter int TAG_W = 4,
    parameter int XLEN  = `XLEN
);
    logic [1:0]       ic_command;
    logic [XLEN-1:0]  ic_addr;
    logic [1:0]       dc_command;
    logic [XLEN-1:0]  dc_addr;
    logic [63:0]      dc_data;
    logic [TAG_W-1:0] mem_response;
    logic [63:0]      mem_data;
    logic [TAG_W-1:0] mem_tag;

    logic [1:0]       proc2mem_command;
    logic [XLEN-1:0]  proc2mem_addr;
    logic [63:0]      proc2mem_data;
    logic [TAG_W-1:0] ic_response;
    logic [63:0]      ic_data;
    logic [TAG_W-1:0] ic_tag;
    logic [TAG_W-1:0] dc_response;
    logic [63:0]      dc_data_out;
    logic [TAG_W-1:0] dc_tag;
    logic [TAG_W:0]   ic_outstanding;
    logic [TAG_W:0]   dc_outstanding;

    modport slave (
        input  ic_command, ic_addr, dc_command, dc_addr, dc_data,
               mem_response, mem_data, mem_tag,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
               ic_response, ic_data, ic_tag,
               dc_response, dc_data_out, dc_tag,
               ic_outstanding, dc_outstanding
    );

    modport master (
        output ic_command, ic_addr, dc_command, dc_addr, dc_data,
               mem_response, mem_data, mem_tag,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
               ic_response, ic_data, ic_tag,
               dc_response, dc_data_out, dc_tag,
               ic_outstanding, dc_outstanding
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: shares one 64-bit memory bus between icache and dcache.
// Grant, accept routing and return routing are combinational; a tag-owner table
// steers each data return to the requester that issued the load.
// Optional statistics counters are built when MEM_ARB_STATS_EN is defined.
`ifndef XLEN
`define XLEN 64
`endif

// Per-requester outstanding-load counter, saturating at 2^TAG_W in both directions.
module mem_bus_arbiter_outstanding #(
    parameter int TAG_W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [TAG_W:0] cnt
);
    localparam logic [TAG_W:0] CNT_MAX = {1'b1, {TAG_W{1'b0}}};

    // Simultaneous accept and return cancel out; never wrap past either end.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (inc && !dec && cnt != CNT_MAX)
            cnt <= cnt + 1'b1;
        else if (dec && !inc && cnt != '0)
            cnt <= cnt - 1'b1;
    end
endmodule

module mem_bus_arbiter #(
    parameter int TAG_W        = 4,
    parameter int STARVE_LIMIT = 4,
    parameter int XLEN         = `XLEN
) (
    input  logic clock,
    input  logic reset,
    mem_bus_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0] ic_grant_cnt,
    output logic [31:0] dc_grant_cnt,
    output logic [31:0] ic_stall_cnt
`endif
);
    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam int         SW        = $clog2(STARVE_LIMIT) + 1;
    localparam logic [SW-1:0] LIMIT  = SW'(STARVE_LIMIT);
    localparam int         NTAGS     = 1 << TAG_W;

    logic              ic_req, dc_req;
    logic              ic_win, dc_win;
    logic              accepted, load_acc;
    logic              ret_hit, ret_owner;
    logic [SW-1:0]     starve_cnt;
    logic [NTAGS-1:0]  tbl_valid;
    logic [NTAGS-1:0]  tbl_owner;   // 0 = icache, 1 = dcache
    logic [1:0]        inc_vec, dec_vec;
    logic [1:0][TAG_W:0] out_vec;

    // Pick the winner and pass its command through to memory; route accept and return.
    always_comb begin
        ic_req   = bus.ic_command != BUS_NONE;
        dc_req   = bus.dc_command != BUS_NONE;
        ic_win   = ic_req && (!dc_req || starve_cnt == LIMIT);
        dc_win   = dc_req && !ic_win;

        bus.proc2mem_command = BUS_NONE;
        bus.proc2mem_addr    = {XLEN{1'b0}};
        bus.proc2mem_data    = '0;
        if (ic_win) begin
            bus.proc2mem_command = bus.ic_command;
            bus.proc2mem_addr    = bus.ic_addr;
        end else if (dc_win) begin
            bus.proc2mem_command = bus.dc_command;
            bus.proc2mem_addr    = bus.dc_addr;
            bus.proc2mem_data    = bus.dc_data;
        end

        bus.ic_response = ic_win ? bus.mem_response : '0;
        bus.dc_response = dc_win ? bus.mem_response : '0;

        accepted = (ic_win || dc_win) && bus.mem_response != '0;
        load_acc = accepted && bus.proc2mem_command == BUS_LOAD;

        // Tag 0 is never allocated, so it can never hit.
        ret_hit   = bus.mem_tag != '0 && tbl_valid[bus.mem_tag];
        ret_owner = tbl_owner[bus.mem_tag];

        bus.ic_tag      = '0;
        bus.ic_data     = '0;
        bus.dc_tag      = '0;
        bus.dc_data_out = '0;
        if (ret_hit && !ret_owner) begin
            bus.ic_tag  = bus.mem_tag;
            bus.ic_data = bus.mem_data;
        end else if (ret_hit && ret_owner) begin
            bus.dc_tag      = bus.mem_tag;
            bus.dc_data_out = bus.mem_data;
        end

        inc_vec = {load_acc && dc_win, load_acc && ic_win};
        dec_vec = {ret_hit && ret_owner, ret_hit && !ret_owner};
        bus.ic_outstanding = out_vec[0];
        bus.dc_outstanding = out_vec[1];
    end

    // Count consecutive icache losses; a rejected forced grant keeps icache forced.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            starve_cnt <= '0;
        else if (!ic_req)
            starve_cnt <= '0;
        else if (ic_win) begin
            if (bus.mem_response != '0)
                starve_cnt <= '0;
        end else if (starve_cnt != LIMIT)
            starve_cnt <= starve_cnt + 1'b1;
    end

    // Retire the returning tag first so a same-cycle reallocation of that tag wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tbl_valid <= '0;
            tbl_owner <= '0;
        end else begin
            if (ret_hit)
                tbl_valid[bus.mem_tag] <= 1'b0;
            if (load_acc) begin
                tbl_valid[bus.mem_response] <= 1'b1;
                tbl_owner[bus.mem_response] <= dc_win;
            end
        end
    end

    mem_bus_arbiter_outstanding #(.TAG_W(TAG_W)) u_out [1:0] (
        .clock (clock),
        .reset (reset),
        .inc   (inc_vec),
        .dec   (dec_vec),
        .cnt   (out_vec)
    );

`ifdef MEM_ARB_STATS_EN
    // Free-running grant/stall statistics; wrap naturally at 2^32.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ic_grant_cnt <= '0;
            dc_grant_cnt <= '0;
            ic_stall_cnt <= '0;
        end else begin
            if (accepted && ic_win)
                ic_grant_cnt <= ic_grant_cnt + 1'b1;
            if (accepted && dc_win)
                dc_grant_cnt <= dc_grant_cnt + 1'b1;
            if (ic_req && !(accepted && ic_win))
                ic_stall_cnt <= ic_stall_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, hand-written
// multi-cycle sequences, then random traffic against a tag-map reference model.
`ifndef XLEN
`define XLEN 64
`endif

module tb_mem_bus_arbiter;
    localparam int TAG_W        = 4;
    localparam int STARVE_LIMIT = 4;
    localparam int XLEN         = `XLEN;
    localparam logic [1:0] NONE = 2'd0, LOAD = 2'd1, STORE = 2'd2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    mem_bus_arbiter_if #(.TAG_W(TAG_W), .XLEN(XLEN)) bus ();

`ifdef MEM_ARB_STATS_EN
    logic [31:0] s_icg, s_dcg, s_ics;
`endif

    mem_bus_arbiter #(.TAG_W(TAG_W), .STARVE_LIMIT(STARVE_LIMIT), .XLEN(XLEN)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
`ifdef MEM_ARB_STATS_EN
        ,
        .ic_grant_cnt (s_icg),
        .dc_grant_cnt (s_dcg),
        .ic_stall_cnt (s_ics)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  ic_cmd;
        logic [63:0] ic_addr;
        logic [1:0]  dc_cmd;
        logic [63:0] dc_addr;
        logic [63:0] dc_data;
        logic [3:0]  resp;
        logic [3:0]  tag;
        logic [63:0] mdata;
        logic [1:0]  e_cmd;
        logic [63:0] e_addr;
        logic [63:0] e_data;
        logic [3:0]  e_icr, e_dcr, e_ict, e_dct;
        logic [4:0]  e_ico, e_dco;
    } vec_t;

    vec_t tv[12];

    // reference model state
    int m_own[16];   // -1 free, 0 icache, 1 dcache
    int m_starve, m_ico, m_dco;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] icc, input logic [63:0] ica,
                         input logic [1:0] dcc, input logic [63:0] dca, input logic [63:0] dcd,
                         input logic [3:0] rsp, input logic [3:0] tg, input logic [63:0] md);
        bus.ic_command   = icc;
        bus.ic_addr      = XLEN'(ica);
        bus.dc_command   = dcc;
        bus.dc_addr      = XLEN'(dca);
        bus.dc_data      = dcd;
        bus.mem_response = rsp;
        bus.mem_tag      = tg;
        bus.mem_data     = md;
    endtask

    task automatic idle();
        drive(NONE, 0, NONE, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_starve = 0; m_ico = 0; m_dco = 0;
        for (int i = 0; i < 16; i++) m_own[i] = -1;
    endtask

    function automatic vec_t mk(input logic [1:0] icc, input logic [63:0] ica,
                                input logic [1:0] dcc, input logic [63:0] dca, input logic [63:0] dcd,
                                input logic [3:0] rsp, input logic [3:0] tg, input logic [63:0] md,
                                input logic [1:0] ec, input logic [63:0] ea, input logic [63:0] ed,
                                input logic [3:0] eicr, input logic [3:0] edcr,
                                input logic [3:0] eict, input logic [3:0] edct,
                                input logic [4:0] eico, input logic [4:0] edco);
        vec_t v;
        v.ic_cmd = icc; v.ic_addr = ica; v.dc_cmd = dcc; v.dc_addr = dca; v.dc_data = dcd;
        v.resp = rsp; v.tag = tg; v.mdata = md;
        v.e_cmd = ec; v.e_addr = ea; v.e_data = ed;
        v.e_icr = eicr; v.e_dcr = edcr; v.e_ict = eict; v.e_dct = edct;
        v.e_ico = eico; v.e_dco = edco;
        return v;
    endfunction

    // Arbitration by the stated rules: lone requester wins; dcache preferred unless icache starved.
    task automatic model_step(input bit check, input string pfx);
        int  win, hit, own, acc;
        logic [1:0]  cmd;
        logic [63:0] ea, ed;
        logic [3:0]  r, t;
        bit ic_req, dc_req;
        ic_req = bus.ic_command != NONE;
        dc_req = bus.dc_command != NONE;
        r = bus.mem_response;
        t = bus.mem_tag;
        if (ic_req && dc_req) win = (m_starve == STARVE_LIMIT) ? 1 : 2;
        else if (ic_req)      win = 1;
        else if (dc_req)      win = 2;
        else                  win = 0;
        cmd = (win == 1) ? bus.ic_command : (win == 2) ? bus.dc_command : NONE;
        ea  = (win == 1) ? 64'(bus.ic_addr) : (win == 2) ? 64'(bus.dc_addr) : 64'd0;
        ed  = (win == 2) ? bus.dc_data : 64'd0;
        hit = (t != 0 && m_own[t] >= 0) ? 1 : 0;
        own = hit ? m_own[t] : -1;
        if (check) begin
            chk({pfx, ".cmd"},  64'(bus.proc2mem_command), 64'(cmd));
            chk({pfx, ".addr"}, 64'(bus.proc2mem_addr), ea);
            chk({pfx, ".data"}, bus.proc2mem_data, ed);
            chk({pfx, ".icr"},  64'(bus.ic_response), (win == 1) ? 64'(r) : 64'd0);
            chk({pfx, ".dcr"},  64'(bus.dc_response), (win == 2) ? 64'(r) : 64'd0);
            chk({pfx, ".ict"},  64'(bus.ic_tag), (own == 0) ? 64'(t) : 64'd0);
            chk({pfx, ".icd"},  bus.ic_data, (own == 0) ? bus.mem_data : 64'd0);
            chk({pfx, ".dct"},  64'(bus.dc_tag), (own == 1) ? 64'(t) : 64'd0);
            chk({pfx, ".dcd"},  bus.dc_data_out, (own == 1) ? bus.mem_data : 64'd0);
            chk({pfx, ".ico"},  64'(bus.ic_outstanding), 64'(m_ico));
            chk({pfx, ".dco"},  64'(bus.dc_outstanding), 64'(m_dco));
        end
        acc = (win != 0 && r != 0 && cmd == LOAD) ? 1 : 0;
        if (acc == 1 && win == 1 && own != 0 && m_ico < 16) m_ico++;
        if (acc == 1 && win == 2 && own != 1 && m_dco < 16) m_dco++;
        if (own == 0 && !(acc == 1 && win == 1) && m_ico > 0) m_ico--;
        if (own == 1 && !(acc == 1 && win == 2) && m_dco > 0) m_dco--;
        if (hit == 1) m_own[t] = -1;
        if (acc == 1) m_own[r] = win - 1;
        if (!ic_req)                m_starve = 0;
        else if (win == 1)          m_starve = (r != 0) ? 0 : m_starve;
        else if (m_starve < STARVE_LIMIT) m_starve++;
    endtask

    initial begin
        idle();
        // Directed rows; outstanding expectations are the values before the row's clock edge.
        tv[0]  = mk(NONE, 0,      NONE, 0, 0,    0, 0, 0,                      NONE,  0,      0,    0, 0, 0, 0, 0, 0);
        tv[1]  = mk(LOAD, 'h100,  NONE, 0, 0,    3, 0, 0,                      LOAD,  'h100,  0,    3, 0, 0, 0, 0, 0);
        tv[2]  = mk(NONE, 0,      NONE, 0, 0,    0, 3, 64'hDEADBEEF_CAFEF00D,  NONE,  0,      0,    0, 0, 3, 0, 1, 0);
        tv[3]  = mk(NONE, 0,      NONE, 0, 0,    0, 3, 64'h1111,               NONE,  0,      0,    0, 0, 0, 0, 0, 0);
        tv[4]  = mk(NONE, 0,      STORE,'h200,'h55, 5, 0, 0,                   STORE, 'h200,  'h55, 0, 5, 0, 0, 0, 0);
        tv[5]  = mk(NONE, 0,      NONE, 0, 0,    0, 5, 64'h1234,               NONE,  0,      0,    0, 0, 0, 0, 0, 0);
        tv[6]  = mk(LOAD, 'h300,  NONE, 0, 0,    7, 0, 0,                      LOAD,  'h300,  0,    7, 0, 0, 0, 0, 0);
        tv[7]  = mk(NONE, 0,      LOAD, 'h400, 0, 7, 7, 64'hA5A5,              LOAD,  'h400,  0,    0, 7, 7, 0, 1, 0);
        tv[8]  = mk(NONE, 0,      NONE, 0, 0,    0, 7, 64'hBEEF,               NONE,  0,      0,    0, 0, 0, 7, 0, 1);
        tv[9]  = mk(NONE, 0,      NONE, 0, 0,    0, 0, 64'hFFFF,               NONE,  0,      0,    0, 0, 0, 0, 0, 0);
        tv[10] = mk(LOAD, 'h500,  LOAD, 'h600, 0, 2, 0, 0,                     LOAD,  'h600,  0,    0, 2, 0, 0, 0, 0);
        tv[11] = mk(LOAD, 'h500,  LOAD, 'h600, 0, 0, 0, 0,                     LOAD,  'h600,  0,    0, 0, 0, 0, 0, 1);

        #2;
        // reset state while reset is held
        chk("rst.cmd", 64'(bus.proc2mem_command), 64'(NONE));
        chk("rst.ico", 64'(bus.ic_outstanding), 0);
        chk("rst.dco", 64'(bus.dc_outstanding), 0);
        do_reset();

        for (int i = 0; i < 12; i++) begin
            drive(tv[i].ic_cmd, tv[i].ic_addr, tv[i].dc_cmd, tv[i].dc_addr, tv[i].dc_data,
                  tv[i].resp, tv[i].tag, tv[i].mdata);
            #2;
            chk($sformatf("r%0d.cmd", i),  64'(bus.proc2mem_command), 64'(tv[i].e_cmd));
            chk($sformatf("r%0d.addr", i), 64'(bus.proc2mem_addr), tv[i].e_addr);
            chk($sformatf("r%0d.data", i), bus.proc2mem_data, tv[i].e_data);
            chk($sformatf("r%0d.icr", i),  64'(bus.ic_response), 64'(tv[i].e_icr));
            chk($sformatf("r%0d.dcr", i),  64'(bus.dc_response), 64'(tv[i].e_dcr));
            chk($sformatf("r%0d.ict", i),  64'(bus.ic_tag), 64'(tv[i].e_ict));
            chk($sformatf("r%0d.icd", i),  bus.ic_data, (tv[i].e_ict != 0) ? tv[i].mdata : 64'd0);
            chk($sformatf("r%0d.dct", i),  64'(bus.dc_tag), 64'(tv[i].e_dct));
            chk($sformatf("r%0d.dcd", i),  bus.dc_data_out, (tv[i].e_dct != 0) ? tv[i].mdata : 64'd0);
            chk($sformatf("r%0d.ico", i),  64'(bus.ic_outstanding), 64'(tv[i].e_ico));
            chk($sformatf("r%0d.dco", i),  64'(bus.dc_outstanding), 64'(tv[i].e_dco));
            tick();
        end

        // Starvation: dcache wins four in a row, then icache gets one, repeating.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            logic [3:0] rr;
            rr = 4'((k % 15) + 1);
            drive(LOAD, 'h1000, LOAD, 'h2000, 0, rr, 0, 0);
            #2;
            chk($sformatf("stv%0d.addr", k), 64'(bus.proc2mem_addr), (k % 5 == 4) ? 64'h1000 : 64'h2000);
            chk($sformatf("stv%0d.icr", k),  64'(bus.ic_response), (k % 5 == 4) ? 64'(rr) : 64'd0);
            tick();
        end

        // A rejected forced icache grant keeps icache forced next cycle.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(LOAD, 'h1000, LOAD, 'h2000, 0, 1, 0, 0);
            tick();
        end
        drive(LOAD, 'h1000, LOAD, 'h2000, 0, 0, 0, 0);
        #2;
        chk("rej.addr", 64'(bus.proc2mem_addr), 64'h1000);
        chk("rej.icr",  64'(bus.ic_response), 0);
        chk("rej.dcr",  64'(bus.dc_response), 0);
        tick();
        drive(LOAD, 'h1000, LOAD, 'h2000, 0, 2, 0, 0);
        #2;
        chk("rej2.addr", 64'(bus.proc2mem_addr), 64'h1000);
        chk("rej2.icr",  64'(bus.ic_response), 2);
        tick();
        drive(LOAD, 'h1000, LOAD, 'h2000, 0, 3, 0, 0);
        #2;
        chk("rej3.addr", 64'(bus.proc2mem_addr), 64'h2000);
        tick();

        // Reset with three loads outstanding drops their later returns.
        do_reset();
        drive(LOAD, 'h10, NONE, 0, 0, 1, 0, 0); tick();
        drive(LOAD, 'h18, NONE, 0, 0, 2, 0, 0); tick();
        drive(NONE, 0, LOAD, 'h20, 0, 3, 0, 0); tick();
        idle();
        #2;
        chk("pre.ico", 64'(bus.ic_outstanding), 2);
        chk("pre.dco", 64'(bus.dc_outstanding), 1);
        reset = 1'b1;
        #1;
        chk("arst.ico", 64'(bus.ic_outstanding), 0);
        chk("arst.dco", 64'(bus.dc_outstanding), 0);
        tick();
        reset = 1'b0;
        drive(NONE, 0, NONE, 0, 0, 0, 1, 64'h77);
        #2;
        chk("old1.ict", 64'(bus.ic_tag), 0);
        chk("old1.dct", 64'(bus.dc_tag), 0);
        tick();
        drive(NONE, 0, NONE, 0, 0, 0, 3, 64'h88);
        #2;
        chk("old3.dct", 64'(bus.dc_tag), 0);
        chk("old3.ict", 64'(bus.ic_tag), 0);
        tick();

        // Random traffic against the reference model.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            logic [1:0]  icc, dcc;
            logic [3:0]  rr, tg;
            icc = 2'($urandom_range(0, 1));
            dcc = 2'($urandom_range(0, 2));
            rr  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            tg  = 4'($urandom_range(0, 15));
            drive(icc, {$urandom, $urandom} & ~64'h7, dcc, {$urandom, $urandom},
                  {$urandom, $urandom}, rr, tg, {$urandom, $urandom});
            #2;
            model_step(1'b1, $sformatf("rnd%0d", k));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
